// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared sizing for the register-file port arbiter.
package regfile_arb_pkg;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 1024;
  localparam int MASK_W = 32;
  localparam int STARVE_MAX = 4;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int ID_W = id_w(NRD);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first valid requester at or after the pointer, wrapping.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N = regfile_arb_pkg::NRD,
  parameter int IW = regfile_arb_pkg::ID_W
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // Walk distances from farthest to nearest so the nearest valid one is kept.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      for (int i = 0; i < N; i++)
        if (valid_i[i] && i == (int'(ptr_i) + k) % N) begin
          gnt_o = '0;
          gnt_o[i] = 1'b1;
          idx_o = IW'(i);
          any_o = 1'b1;
        end
  end
endmodule

// File: rtl/regfile_port_arb.sv
// regfile_port_arb: round-robin read arbitration and priority write arbitration
// with starvation relief, in front of a 1R1W write-first register-file RAM.
module regfile_port_arb
  import regfile_arb_pkg::*;
#(
  parameter int NRD = regfile_arb_pkg::NRD,
  parameter int NWR = regfile_arb_pkg::NWR,
  parameter int ADDR_W = regfile_arb_pkg::ADDR_W,
  parameter int DATA_W = regfile_arb_pkg::DATA_W,
  parameter int MASK_W = regfile_arb_pkg::MASK_W,
  parameter int STARVE_MAX = regfile_arb_pkg::STARVE_MAX,
  localparam int IW = id_w(NRD)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NRD-1:0]        rd_req_valid,
  input  logic [NRD*ADDR_W-1:0] rd_req_addr,
  output logic [NRD-1:0]        rd_req_ready,
  output logic                  rd_resp_valid,
  output logic [IW-1:0]         rd_resp_id,
  output logic [DATA_W-1:0]     rd_resp_data,
  input  logic [NWR-1:0]        wr_req_valid,
  input  logic [NWR*ADDR_W-1:0] wr_req_addr,
  input  logic [NWR*DATA_W-1:0] wr_req_data,
  input  logic [NWR*MASK_W-1:0] wr_req_mask,
  output logic [NWR-1:0]        wr_req_ready,
  output logic                  R0_en,
  output logic [ADDR_W-1:0]     R0_addr,
  input  logic [DATA_W-1:0]     R0_data,
  output logic                  W0_en,
  output logic [ADDR_W-1:0]     W0_addr,
  output logic [DATA_W-1:0]     W0_data,
  output logic [MASK_W-1:0]     W0_mask
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [NRD-1:0] rd_v, rd_gnt;
  logic [IW-1:0]  rd_idx, rr_ptr_q, rr_ptr_d, rd_resp_id_q;
  logic           rd_any, rd_resp_valid_q;
  logic [NWR-1:0] wr_v, wr_gnt;
  logic [SW-1:0]  starve_q, starve_d;
  logic           force_wr1;
  // Requests are masked while in reset so no grant can leak out.
  assign rd_v = rd_req_valid & {NRD{reset_n}};
  assign wr_v = wr_req_valid & {NWR{reset_n}};
  rr_arbiter #(.N(NRD), .IW(IW)) u_rr (
    .valid_i(rd_v),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (rd_gnt),
    .idx_o  (rd_idx),
    .any_o  (rd_any)
  );
  assign rd_req_ready  = rd_gnt;
  assign R0_en         = rd_any;
  assign rd_resp_valid = rd_resp_valid_q;
  assign rd_resp_id    = rd_resp_id_q;
  assign rd_resp_data  = R0_data;
  assign rr_ptr_d      = rd_any ? IW'((int'(rd_idx) + 1) % NRD) : rr_ptr_q;
  assign force_wr1     = wr_v[1] && starve_q == SW'(STARVE_MAX);
  always_comb begin
    R0_addr = '0;
    for (int i = 0; i < NRD; i++)
      if (rd_gnt[i]) R0_addr = rd_req_addr[i*ADDR_W +: ADDR_W];
  end
  always_comb begin
    wr_gnt = '0;
    for (int i = NWR - 1; i >= 0; i--)
      if (wr_v[i]) begin
        wr_gnt = '0;
        wr_gnt[i] = 1'b1;
      end
    if (force_wr1) begin
      wr_gnt = '0;
      wr_gnt[1] = 1'b1;
    end
    starve_d = (!wr_v[1] || wr_gnt[1]) ? '0
             : starve_q + SW'(starve_q != SW'(STARVE_MAX));
    W0_addr = '0;
    W0_data = '0;
    W0_mask = '0;
    for (int i = 0; i < NWR; i++)
      if (wr_gnt[i]) begin
        W0_addr = wr_req_addr[i*ADDR_W +: ADDR_W];
        W0_data = wr_req_data[i*DATA_W +: DATA_W];
        W0_mask = wr_req_mask[i*MASK_W +: MASK_W];
      end
  end
  assign wr_req_ready = wr_gnt;
  assign W0_en        = |wr_gnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rr_ptr_q        <= '0;
      starve_q        <= '0;
      rd_resp_valid_q <= 1'b0;
      rd_resp_id_q    <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      starve_q        <= starve_d;
      rd_resp_valid_q <= rd_any;
      rd_resp_id_q    <= rd_idx;
    end
endmodule

// File: doc/regfile_port_arb.md
REGFILE_PORT_ARB -- requirements
Module: regfile_port_arb

Interface
REQ-001 SHALL have parameter NRD, default 4: number of read requesters.
REQ-002 SHALL have parameter NWR, default 2: number of write requesters; requester 0 has high priority, requester 1 low.
REQ-003 SHALL have parameter ADDR_W, default 9: register-file row address width (512 rows).
REQ-004 SHALL have parameter DATA_W, default 1024: row width (32 lanes x 32 bits).
REQ-005 SHALL have parameter MASK_W, default 32: per-lane write mask width.
REQ-006 SHALL have parameter STARVE_MAX, default 4: consecutive denied cycles before write requester 1 is forced through.
REQ-007 SHALL have ports (name direction width meaning):
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_req_valid  in  NRD  per-requester read request
- rd_req_addr  in  NRD*ADDR_W  per-requester row address, requester i at slice i
- rd_req_ready  out  NRD  one-hot read grant
- rd_resp_valid  out  1  read data valid
- rd_resp_id  out  clog2(NRD)  requester owning the response
- rd_resp_data  out  DATA_W  read row
- wr_req_valid  in  NWR  per-requester write request
- wr_req_addr  in  NWR*ADDR_W  write row addresses
- wr_req_data  in  NWR*DATA_W  write rows
- wr_req_mask  in  NWR*MASK_W  lane enables
- wr_req_ready  out  NWR  one-hot write grant
- R0_en, R0_addr  out  1, ADDR_W  RAM read port
- R0_data  in  DATA_W  RAM read data, valid one cycle after R0_en
- W0_en, W0_addr, W0_data, W0_mask  out  1, ADDR_W, DATA_W, MASK_W  RAM write port

Function
REQ-008 Read grant SHALL be round-robin: the first valid requester at or after rr_ptr (modulo NRD) wins; at most one rd_req_ready bit is high.
REQ-009 rd_req_ready SHALL be combinational from rd_req_valid and rr_ptr; a transfer occurs when valid and ready are both high.
REQ-010 On a read grant, R0_en SHALL be 1 and R0_addr SHALL equal the winner's address in the same cycle; with no valid request, R0_en SHALL be 0.
REQ-011 rr_ptr SHALL advance to (winner+1) mod NRD on a grant and hold otherwise.
REQ-012 rd_resp_valid and rd_resp_id SHALL be registered copies of the grant and winner index: latency exactly 1 cycle; rd_resp_data SHALL be R0_data passed through; no response backpressure.
REQ-013 Write grant SHALL go to requester 0 when valid, except as stated in REQ-014; W0_en/addr/data/mask SHALL carry the winner's fields in the grant cycle.
REQ-014 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle requester 1 is valid and not granted, and clear when requester 1 is granted or deasserts; when starve_cnt equals STARVE_MAX, requester 1 SHALL be granted over requester 0.
REQ-015 A write with wr_req_mask all zero SHALL still be granted with W0_en=1.
REQ-016 Read and write ports SHALL operate independently in the same cycle; a same-cycle read and write to one row returns the newly written lanes (RAM is write-first); no stall or bypass logic.

Reset
REQ-017 While reset_n is low: rr_ptr=0, starve_cnt=0, rd_resp_valid=0, rd_resp_id=0, and all rd_req_ready, wr_req_ready, R0_en and W0_en SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL drop any pending read response; no response is emitted after reset_n rises for a grant issued before.

Structure
REQ-019 NRD, NWR, ADDR_W, DATA_W, MASK_W, STARVE_MAX and the derived ID width SHALL live in shared package regfile_arb_pkg.
REQ-020 The read round-robin SHALL be a sub-module rr_arbiter (valid vector and pointer in, one-hot grant and index out).

Verification
REQ-021 All 4 read requesters valid for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; rd_resp_id same sequence one cycle later.
REQ-022 Write row 5 = 0xA5.. full mask, next cycle read row 5 by requester 2 -> rd_resp_valid=1, id=2, data=0xA5.. one cycle after grant.
REQ-023 Write requesters 0 and 1 both valid continuously -> requester 0 granted 4 cycles, requester 1 on cycle 5, pattern repeats.
REQ-024 Same-cycle write row 7 mask=0x1 data lane0=0x1234 and read row 7 -> response lane0=0x1234, other lanes unchanged.
REQ-025 Assert reset_n low the cycle after a read grant -> rd_resp_valid stays 0, rr_ptr restarts at requester 0.
